// File: rtl/pipe_hazard_pkg.sv
// +------------------------------------------------------------------+
// | pipe_hazard_pkg : shared types for the pipeline hazard controller|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package pipe_hazard_pkg;

  // Tag register fields are sized for the widest supported register file.
  localparam int RA_W_MAX = 8;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_STALL  = 2'd1,
    HZ_FLUSH  = 2'd2,
    HZ_FREEZE = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] rd;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic [RA_W_MAX-1:0] rs;
    logic [RA_W_MAX-1:0] rt;
  } stage_tag_t;

  localparam int TAG_W = $bits(stage_tag_t);

  // regwrite is only ever set with a non-zero rd, so source 0 can never hit.
  function automatic logic tag_hit(stage_tag_t t, logic [RA_W_MAX-1:0] src);
    return t.valid & t.regwrite & (t.rd == src);
  endfunction

  function automatic fwd_sel_t fwd_pick(logic mem_hit, logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hz_stage_tag.sv
// +------------------------------------------------------------------+
// | hz_stage_tag : one pipeline-stage tag register, enable + bubble  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module hz_stage_tag
  import pipe_hazard_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             bubble_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tag_o
);

  logic [TAG_W-1:0] tag_d;
  logic [TAG_W-1:0] tag_q;

  always_comb begin
    tag_d = tag_q;
    if (en_i) begin
      tag_d = bubble_i ? '0 : tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_o = tag_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// +------------------------------------------------------------------+
// | pipe_hazard_ctrl : 5-stage pipeline hazard / forwarding control  |
// | Optional perf counters: define HZ_PERF_EN.        Rev 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int RA_W         = 5,
  parameter int BRANCH_IN_ID = 1,
  parameter int WAIT_MAX     = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_valid_i,
  input  logic [RA_W-1:0]  id_rs_i,
  input  logic             id_rs_used_i,
  input  logic [RA_W-1:0]  id_rt_i,
  input  logic             id_rt_used_i,
  input  logic [RA_W-1:0]  id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_memwrite_i,
  input  logic             id_branch_i,
  input  logic             br_taken_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_write_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_bubble_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             id_fwd_a_o,
  output logic             id_fwd_b_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int   WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic BR_ID  = (BRANCH_IN_ID != 0);

  stage_tag_t       id_tag, ex_tag, mem_tag, wb_tag;
  logic [TAG_W-1:0] ex_bits, mem_bits, wb_bits;
  hz_state_t        hz_state;
  logic             tag_en;
  logic             freeze, load_use, br_stall, ex_hits_id, mem_hits_id;
  logic [WAIT_W-1:0] mem_wait_d, mem_wait_q;
  logic             err_d, err_q;

  // Unread sources are stored as register 0 so they never match.
  always_comb begin
    id_tag          = '0;
    id_tag.valid    = id_valid_i;
    id_tag.rd       = RA_W_MAX'(id_rd_i);
    id_tag.regwrite = id_regwrite_i & (id_rd_i != '0);
    id_tag.memread  = id_memread_i;
    id_tag.memwrite = id_memwrite_i;
    id_tag.rs       = id_rs_used_i ? RA_W_MAX'(id_rs_i) : '0;
    id_tag.rt       = id_rt_used_i ? RA_W_MAX'(id_rt_i) : '0;
  end

  assign ex_tag  = ex_bits;
  assign mem_tag = mem_bits;
  assign wb_tag  = wb_bits;

  assign ex_hits_id  = id_valid_i & (tag_hit(ex_tag, id_tag.rs)  | tag_hit(ex_tag, id_tag.rt));
  assign mem_hits_id = id_valid_i & (tag_hit(mem_tag, id_tag.rs) | tag_hit(mem_tag, id_tag.rt));
  assign load_use    = ex_hits_id & ex_tag.memread;
  assign br_stall    = BR_ID & id_branch_i & (ex_hits_id | (mem_hits_id & mem_tag.memread));
  assign freeze      = mem_tag.valid & (mem_tag.memread | mem_tag.memwrite) & ~dmem_ready_i;

  always_comb begin
    if (freeze) begin
      hz_state = HZ_FREEZE;
    end else if (load_use | br_stall) begin
      hz_state = HZ_STALL;
    end else if (br_taken_i) begin
      hz_state = HZ_FLUSH;
    end else begin
      hz_state = HZ_RUN;
    end
  end

  always_comb begin
    pc_write_o      = 1'b1;
    if_id_write_o   = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_write_o   = 1'b1;
    id_ex_bubble_o  = 1'b0;
    ex_mem_write_o  = 1'b1;
    mem_wb_bubble_o = 1'b0;
    case (hz_state)
      HZ_FREEZE: begin
        pc_write_o      = 1'b0;
        if_id_write_o   = 1'b0;
        id_ex_write_o   = 1'b0;
        ex_mem_write_o  = 1'b0;
        mem_wb_bubble_o = 1'b1;
      end
      HZ_STALL: begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        id_ex_bubble_o = 1'b1;
      end
      HZ_FLUSH: begin
        if_id_flush_o  = 1'b1;
        id_ex_bubble_o = ~BR_ID;
      end
      default: ;
    endcase
  end

  assign tag_en = (hz_state != HZ_FREEZE);

  hz_stage_tag u_ex_tag  (.clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(tag_en),
                          .bubble_i(id_ex_bubble_o), .tag_i(id_tag),   .tag_o(ex_bits));
  hz_stage_tag u_mem_tag (.clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(tag_en),
                          .bubble_i(1'b0),           .tag_i(ex_bits),  .tag_o(mem_bits));
  hz_stage_tag u_wb_tag  (.clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(tag_en),
                          .bubble_i(1'b0),           .tag_i(mem_bits), .tag_o(wb_bits));

  assign fwd_a_o    = fwd_pick(tag_hit(mem_tag, ex_tag.rs), tag_hit(wb_tag, ex_tag.rs));
  assign fwd_b_o    = fwd_pick(tag_hit(mem_tag, ex_tag.rt), tag_hit(wb_tag, ex_tag.rt));
  assign id_fwd_a_o = BR_ID & tag_hit(mem_tag, id_tag.rs);
  assign id_fwd_b_o = BR_ID & tag_hit(mem_tag, id_tag.rt);

  // err_o rises on the edge that closes the WAIT_MAX-th consecutive wait cycle.
  always_comb begin
    mem_wait_d = '0;
    err_d      = err_q;
    if (freeze) begin
      mem_wait_d = mem_wait_q;
      if (mem_wait_q != WAIT_W'(WAIT_MAX)) begin
        mem_wait_d = mem_wait_q + WAIT_W'(1);
      end
      if (mem_wait_q >= WAIT_W'(WAIT_MAX - 1)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_wait_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_wait_q <= mem_wait_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef HZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (((hz_state == HZ_STALL) || (hz_state == HZ_FREEZE)) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((hz_state == HZ_FLUSH) && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

  logic unused_tag_bits;
  assign unused_tag_bits = ^{ex_tag.memwrite, mem_tag.rs, mem_tag.rt,
                             wb_tag.memread, wb_tag.memwrite, wb_tag.rs, wb_tag.rt};

endmodule

`default_nettype wire
